// File: rtl/qos_pkg.sv
// qos_pkg: shared types and constants for the QoS read-side scheduler.
//   NUM_BUF  - number of packet buffers served
//   CNT_W    - width of one buffer occupancy field
//   AGE_W    - width of one starvation age register
//   SERVED_W - width of one served-packet counter
//   qos_state_e - scheduler FSM states
//   onehot()    - index to one-hot read request
package qos_pkg;

  localparam int NUM_BUF  = 4;
  localparam int CNT_W    = 3;
  localparam int AGE_W    = 3;
  localparam int SERVED_W = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } qos_state_e;

  function automatic logic [NUM_BUF-1:0] onehot(input logic [1:0] idx);
    logic [NUM_BUF-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/qos_prio_select.sv
// qos_prio_select: combinational winner selection for one scheduling decision.
//   counts       in  packed occupancies {buf3..buf0}
//   ages         in  packed starvation ages {buf3..buf0}
//   full_level   in  occupancy at or above which a buffer is full
//   starve_limit in  age at which a non-empty buffer is starved
//   winner       out selected buffer index (valid when any_valid)
//   any_valid    out at least one buffer is non-empty
// Precedence: starved, then full, then plain non-empty; highest index wins
// inside each class. Only non-empty buffers are eligible in any class, so a
// buffer left at the starve age after an aborted grant cannot win once empty.
module qos_prio_select import qos_pkg::*; (
  input  logic [NUM_BUF*CNT_W-1:0] counts,
  input  logic [NUM_BUF*AGE_W-1:0] ages,
  input  logic [CNT_W-1:0]         full_level,
  input  logic [AGE_W-1:0]         starve_limit,
  output logic [1:0]               winner,
  output logic                     any_valid
);

  logic       starve_hit, full_hit, busy_hit;
  logic [1:0] starve_idx, full_idx, busy_idx;

  always_comb begin
    starve_hit = 1'b0;
    full_hit   = 1'b0;
    busy_hit   = 1'b0;
    starve_idx = 2'd0;
    full_idx   = 2'd0;
    busy_idx   = 2'd0;
    // Ascending scan: later (higher) indices overwrite earlier hits.
    for (int i = 0; i < NUM_BUF; i++) begin
      if (counts[i*CNT_W +: CNT_W] != '0) begin
        busy_hit = 1'b1;
        busy_idx = 2'(i);
        if (ages[i*AGE_W +: AGE_W] == starve_limit) begin
          starve_hit = 1'b1;
          starve_idx = 2'(i);
        end
        if (counts[i*CNT_W +: CNT_W] >= full_level) begin
          full_hit = 1'b1;
          full_idx = 2'(i);
        end
      end
    end
    winner    = starve_hit ? starve_idx : (full_hit ? full_idx : busy_idx);
    any_valid = busy_hit;
  end

endmodule

// File: rtl/qos_scheduler.sv
// qos_scheduler: read-side scheduler for four packet buffers.
//   clk, rst_n  in  clock, asynchronous active-low reset
//   tick        in  one-cycle scheduling strobe
//   data_count  in  packed occupancies {buf3..buf0}, 3 bits each
//   read_ack    in  per-buffer read acknowledge
//   read_from   out one-hot read request, 0 when idle
//   grant_id    out current or last granted buffer
//   grant_valid out high exactly while read_from != 0
//   served_cnt  out packed served counters {s3..s0}, 7 bits each
//   ack_timeout out one-cycle pulse when a grant aborts
//   busy        out high in GRANT (exposes the FSM state)
//
// Handshake: read_from is raised one cycle after an accepted tick and held
// unchanged until the edge at which read_ack[grant_id] is sampled high (or the
// timeout expires); it drops at that edge. Other read_ack bits are ignored.
module qos_scheduler import qos_pkg::*; #(
  parameter int FULL_LEVEL   = 6,
  parameter int STARVE_LIMIT = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [NUM_BUF*CNT_W-1:0]  data_count,
  input  logic [NUM_BUF-1:0]        read_ack,
  output logic [NUM_BUF-1:0]        read_from,
  output logic [1:0]                grant_id,
  output logic                      grant_valid,
  output logic [NUM_BUF*SERVED_W-1:0] served_cnt,
  output logic                      ack_timeout,
  output logic                      busy
);

  localparam logic [CNT_W-1:0]    FULL_LV  = CNT_W'(FULL_LEVEL);
  localparam logic [AGE_W-1:0]    STARVE   = AGE_W'(STARVE_LIMIT);
  localparam logic [7:0]          TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [SERVED_W-1:0] SRV_ONE  = SERVED_W'(1);

  qos_state_e                 state;
  logic [NUM_BUF*AGE_W-1:0]   ages;
  logic [7:0]                 tmo_cnt;
  // Set for the first IDLE cycle after a grant ends; a tick in that cycle is
  // ignored, which enforces the 3-cycle minimum grant-to-grant spacing.
  logic                       cool;
  logic [1:0]                 winner;
  logic                       any_valid;

  qos_prio_select u_prio (
    .counts       (data_count),
    .ages         (ages),
    .full_level   (FULL_LV),
    .starve_limit (STARVE),
    .winner       (winner),
    .any_valid    (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      read_from   <= '0;
      grant_id    <= 2'd0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
      ack_timeout <= 1'b0;
      served_cnt  <= '0;
      ages        <= '0;
      tmo_cnt     <= 8'd0;
      cool        <= 1'b0;
    end else begin
      ack_timeout <= 1'b0;
      case (state)
        IDLE: begin
          cool <= 1'b0;
          if (tick && !cool) begin
            if (any_valid) begin
              state       <= GRANT;
              read_from   <= onehot(winner);
              grant_id    <= winner;
              grant_valid <= 1'b1;
              busy        <= 1'b1;
              tmo_cnt     <= 8'd0;
              for (int i = 0; i < NUM_BUF; i++) begin
                if (2'(i) == winner || data_count[i*CNT_W +: CNT_W] == '0)
                  ages[i*AGE_W +: AGE_W] <= '0;
                else if (ages[i*AGE_W +: AGE_W] < STARVE)
                  ages[i*AGE_W +: AGE_W] <= ages[i*AGE_W +: AGE_W] + 1'b1;
              end
            end else begin
              ages <= '0;
            end
          end
        end
        GRANT: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (read_ack[grant_id]) begin
            state       <= IDLE;
            read_from   <= '0;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
            cool        <= 1'b1;
            served_cnt[grant_id*SERVED_W +: SERVED_W] <=
              served_cnt[grant_id*SERVED_W +: SERVED_W] + SRV_ONE;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            read_from   <= '0;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
            cool        <= 1'b1;
            ack_timeout <= 1'b1;
            // Force the aborted buffer to win the next decision if non-empty.
            ages[grant_id*AGE_W +: AGE_W] <= STARVE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qos_scheduler.sv
module tb_qos_scheduler;

  localparam int FULL_LEVEL   = 6;
  localparam int STARVE_LIMIT = 4;
  localparam int ACK_TIMEOUT  = 15;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [11:0] data_count;
  logic [3:0]  read_ack;
  logic [3:0]  read_from;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic [27:0] served_cnt;
  logic        ack_timeout;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (plain integers)
  int m_cnt[4];
  int m_age[4];
  int m_srv[4];

  qos_scheduler #(
    .FULL_LEVEL   (FULL_LEVEL),
    .STARVE_LIMIT (STARVE_LIMIT),
    .ACK_TIMEOUT  (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .data_count  (data_count),
    .read_ack    (read_ack),
    .read_from   (read_from),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .served_cnt  (served_cnt),
    .ack_timeout (ack_timeout),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [27:0] model_served();
    logic [27:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*7 +: 7] = 7'(m_srv[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_age[i] = 0;
      m_srv[i] = 0;
    end
  endtask

  // One scheduling decision from the rules: starved > full > non-empty,
  // highest index within a class; returns -1 when every buffer is empty.
  task automatic model_decide(output int w);
    w = -1;
    for (int i = 0; i < 4; i++) if (m_cnt[i] > 0 && m_age[i] == STARVE_LIMIT) w = i;
    if (w < 0) for (int i = 0; i < 4; i++) if (m_cnt[i] >= FULL_LEVEL) w = i;
    if (w < 0) for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) w = i;
    for (int i = 0; i < 4; i++) begin
      if (w < 0 || i == w || m_cnt[i] == 0) m_age[i] = 0;
      else if (m_age[i] < STARVE_LIMIT) m_age[i] = m_age[i] + 1;
    end
  endtask

  // driver tasks
  task automatic set_counts(input int c3, input int c2, input int c1, input int c0);
    m_cnt[3] = c3; m_cnt[2] = c2; m_cnt[1] = c1; m_cnt[0] = c0;
    data_count = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endtask

  // Called at a negedge in an IDLE, tick-acceptable cycle. ack_at is the
  // grant cycle (1-based) in which the ack is driven; > ACK_TIMEOUT = never.
  task automatic grant_round(input int ack_at, input bit cool_tick, output int w);
    logic [3:0] exp_rf;
    bit acked;
    acked = 1'b0;
    tick = 1'b1;
    model_decide(w);
    @(negedge clk);
    tick = 1'b0;
    if (w < 0) begin
      check("empty_rf", read_from, 4'd0);
      check("empty_busy", busy, 1'b0);
      return;
    end
    exp_rf = 4'b0001 << w;
    check("grant_rf", read_from, exp_rf);
    check("grant_id", grant_id, w);
    check("grant_valid", grant_valid, 1'b1);
    check("grant_busy", busy, 1'b1);
    for (int c = 1; c <= ACK_TIMEOUT; c++) begin
      read_ack = 4'($urandom_range(0, 15)) & ~exp_rf;
      if (c == ack_at) read_ack = read_ack | exp_rf;
      tick = 1'($urandom_range(0, 1));  // ticks in GRANT must be dropped
      @(negedge clk);
      read_ack = '0;
      tick = 1'b0;
      if (c == ack_at) begin
        acked = 1'b1;
        break;
      end
      if (c < ACK_TIMEOUT) check("hold_rf", read_from, exp_rf);
    end
    if (acked) m_srv[w] = (m_srv[w] + 1) % 128;
    else m_age[w] = STARVE_LIMIT;
    check("release_rf", read_from, 4'd0);
    check("release_valid", grant_valid, 1'b0);
    check("release_busy", busy, 1'b0);
    check("release_id", grant_id, w);
    check("ack_timeout", ack_timeout, !acked);
    check("served", served_cnt, model_served());
    tick = cool_tick;  // tick in the first IDLE cycle is ignored
    @(negedge clk);
    tick = 1'b0;
    check("cool_rf", read_from, 4'd0);
    check("pulse_len", ack_timeout, 1'b0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    tick = 1'b0;
    read_ack = '0;
    set_counts(0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rf", read_from, 4'd0);
    check("rst_id", grant_id, 2'd0);
    check("rst_valid", grant_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tmo", ack_timeout, 1'b0);
    check("rst_served", served_cnt, 28'd0);

    // strict priority, then full override
    set_counts(3, 0, 2, 1);
    grant_round(1, 1'b0, w);
    check("strict_s3", served_cnt[27:21], 7'd1);
    set_counts(1, 6, 0, 2);
    grant_round(3, 1'b1, w);
    check("full_id", grant_id, 2'd2);

    // all-empty tick clears ages; then starvation of buf0
    set_counts(0, 0, 0, 0);
    grant_round(1, 1'b0, w);
    set_counts(2, 0, 0, 3);
    for (int r = 0; r < 5; r++) grant_round(2, 1'b0, w);
    check("starve_id", grant_id, 2'd0);

    // timeout on buf1, then forced regrant of buf1 over buf3
    set_counts(0, 0, 0, 0);
    grant_round(1, 1'b0, w);
    set_counts(0, 0, 2, 0);
    grant_round(ACK_TIMEOUT + 1, 1'b0, w);
    set_counts(3, 0, 2, 0);
    grant_round(ACK_TIMEOUT, 1'b1, w);  // ack in the timeout cycle: ack wins
    check("regrant_id", grant_id, 2'd1);

    // served s0 wraps 127 -> 0
    set_counts(0, 0, 0, 4);
    for (int r = 0; r < 128; r++) grant_round(1, 1'b0, w);
    check("wrap_s0", served_cnt[6:0], 7'(m_srv[0]));

    // reset in the middle of a grant
    set_counts(0, 5, 0, 0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("pre_rst_rf", read_from, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rf", read_from, 4'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_served", served_cnt, 28'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_counts(3, 0, 2, 1);
    grant_round(1, 1'b0, w);

    // randomized rounds
    for (int r = 0; r < 150; r++) begin
      set_counts($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 6),
                 $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 6),
                 $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 6),
                 $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 6));
      grant_round($urandom_range(1, ACK_TIMEOUT + 3), 1'($urandom_range(0, 1)), w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
